// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding and sizing helpers for the neuron layer sequencer
package neuron_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_EVAL, ST_DONE} state_e;
   function automatic int calc_res_width(input int k, input int n, input int b, input int m);
      return $clog2(m * ((2 ** k) - 1) * ((2 ** n) - 1) + (2 ** b) - 1);
   endfunction
   // ROM word layout is {bias, weights}; bias starts right above the weight field
   function automatic int bias_lsb(input int m, input int n);
      return m * n;
   endfunction
endpackage

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: time-multiplexes one neuron across a layer, fetching params
// per neuron from ROM and streaming ReLU results out over valid/ready.
module neuron_layer_sequencer
   import neuron_pkg::*;
#(
   parameter int k           = 4,
   parameter int n           = 4,
   parameter int b           = 4,
   parameter int m           = 4,
   parameter int NUM_NEURONS = 8,
   parameter int AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   parameter int res_width   = calc_res_width(k, n, b, m)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [m*k-1:0]       act_in,
   output logic                 busy,
   output logic                 done,
   output logic                 rom_en,
   output logic [AW-1:0]        rom_addr,
   input  logic [m*n+b-1:0]     rom_rdata,
   output logic [m*k-1:0]       nrn_act,
   output logic [m*n-1:0]       nrn_weight,
   output logic [b-1:0]         nrn_bias,
   output logic                 nrn_load,
   output logic                 nrn_rstn,
   input  logic [res_width-1:0] nrn_res,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AW-1:0]        out_idx,
   output logic [res_width-1:0] out_data
);
   localparam int BIAS_LSB = bias_lsb(m, n);
   localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);
   state_e         state_q, state_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [m*k-1:0] act_q, act_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         act_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
      end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      act_d   = act_q;
      case (state_q)
         ST_IDLE: if (start) begin
            act_d   = act_in;
            idx_d   = '0;
            state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_EVAL;
         // the neuron holds its result while we wait, so EVAL can stretch freely
         ST_EVAL: if (out_ready) begin
            state_d = (idx_q == LAST) ? ST_DONE : ST_FETCH;
            idx_d   = (idx_q == LAST) ? idx_q : idx_q + AW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end
   assign busy       = state_q != ST_IDLE;
   assign done       = state_q == ST_DONE;
   assign rom_en     = state_q == ST_FETCH;
   assign rom_addr   = idx_q;
   assign nrn_load   = state_q == ST_LOAD;
   assign nrn_act    = act_q;
   assign nrn_weight = rom_rdata[BIAS_LSB-1:0];
   assign nrn_bias   = rom_rdata[BIAS_LSB +: b];
   assign nrn_rstn   = ~rst;
   assign out_valid  = state_q == ST_EVAL;
   assign out_idx    = idx_q;
   assign out_data   = nrn_res;
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed table-driven bench with ROM and neuron models
module tb_neuron_layer_sequencer;
   typedef struct {
      logic [19:0] word;
      logic [9:0]  exp;
   } vec_t;
   localparam logic [15:0] ACT2 = 16'h2222;
   localparam logic [15:0] ACT5 = 16'h5555;
   logic clk, rst, start, out_ready;
   logic [15:0] act_in;
   logic busy, done, rom_en, nrn_load, nrn_rstn, out_valid;
   logic [2:0] rom_addr, out_idx;
   logic [19:0] rom_rdata;
   logic [15:0] nrn_act;
   logic [15:0] nrn_weight;
   logic [3:0]  nrn_bias;
   logic [9:0]  nrn_res, out_data;
   logic start1;
   logic [15:0] act_in1;
   logic busy1, done1, rom_en1, nrn_load1, nrn_rstn1, out_valid1;
   logic [0:0] rom_addr1, out_idx1;
   logic [19:0] rom_rdata1;
   logic [15:0] nrn_act1, nrn_weight1;
   logic [3:0]  nrn_bias1;
   logic [9:0]  nrn_res1, out_data1;
   vec_t tbl [8];
   logic [19:0] rom [8];
   logic [15:0] na, na1;
   logic [19:0] nw, nw1;
   int checks = 0, errors = 0;
   neuron_layer_sequencer #(.NUM_NEURONS(8)) dut (
      .clk(clk), .rst(rst), .start(start), .act_in(act_in), .busy(busy), .done(done),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .nrn_act(nrn_act),
      .nrn_weight(nrn_weight), .nrn_bias(nrn_bias), .nrn_load(nrn_load), .nrn_rstn(nrn_rstn),
      .nrn_res(nrn_res), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_data(out_data));
   neuron_layer_sequencer #(.NUM_NEURONS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .act_in(act_in1), .busy(busy1), .done(done1),
      .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_rdata(rom_rdata1), .nrn_act(nrn_act1),
      .nrn_weight(nrn_weight1), .nrn_bias(nrn_bias1), .nrn_load(nrn_load1), .nrn_rstn(nrn_rstn1),
      .nrn_res(nrn_res1), .out_valid(out_valid1), .out_ready(1'b1), .out_idx(out_idx1),
      .out_data(out_data1));
   // unsigned activations, signed weights and bias, ReLU output
   function automatic logic [9:0] neuron_eval(input logic [15:0] a, input logic [19:0] w);
      int s;
      s = int'($signed(w[19:16]));
      for (int j = 0; j < 4; j++) s += int'(a[4*j +: 4]) * int'($signed(w[4*j +: 4]));
      return (s < 0) ? 10'd0 : 10'(s);
   endfunction
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (rom_en) rom_rdata <= rom[rom_addr];
      if (rom_en1) rom_rdata1 <= rom[0];
      if (!nrn_rstn) begin na <= '0; nw <= '0; end
      else if (nrn_load) begin na <= nrn_act; nw <= {nrn_bias, nrn_weight}; end
      if (!nrn_rstn1) begin na1 <= '0; nw1 <= '0; end
      else if (nrn_load1) begin na1 <= nrn_act1; nw1 <= {nrn_bias1, nrn_weight1}; end
   end
   assign nrn_res  = neuron_eval(na, nw);
   assign nrn_res1 = neuron_eval(na1, nw1);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run_pass(input int stall_idx, input int stall_n, input int mid_start, output int done_cyc);
      int c, got, stalls;
      start = 1; act_in = ACT2; out_ready = 1;
      @(negedge clk);
      c = 1; got = 0; stalls = 0; done_cyc = -1;
      chk("busy_after_start", busy, 1);
      while (c < 200 && done_cyc < 0) begin
         start  = (c == mid_start);
         act_in = (c == mid_start) ? ACT5 : ACT2;
         if (rom_en) chk("rom_addr", rom_addr, got);
         if (out_valid && out_idx == stall_idx[2:0] && stalls < stall_n) begin
            out_ready = 0;
            stalls++;
            chk("stall_idx", out_idx, stall_idx);
            chk("stall_data", out_data, tbl[stall_idx].exp);
            chk("stall_rom_en", rom_en, 0);
         end else if (out_valid) begin
            out_ready = 1;
            chk("res_idx", out_idx, got);
            chk("res_data", out_data, tbl[got % 8].exp);
            chk("res_cycle", c, 3 * got + 3 + ((stall_idx >= 0 && got >= stall_idx) ? stall_n : 0));
            got++;
         end else out_ready = 1;
         if (done) begin
            done_cyc = c;
            chk("result_count", got, 8);
         end
         @(negedge clk);
         c++;
      end
      start = 0; out_ready = 1;
      if (done_cyc < 0) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
      end else chk("idle_after_done", busy, 0);
   endtask
   initial begin
      int dc;
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      int dc;
      tbl[0] = '{20'h0_1111, 10'd8};
      tbl[1] = '{20'h1_2222, 10'd17};
      tbl[2] = '{20'h2_0103, 10'd10};
      tbl[3] = '{20'hF_FFFF, 10'd0};
      tbl[4] = '{20'h7_7777, 10'd63};
      tbl[5] = '{20'h5_0000, 10'd5};
      tbl[6] = '{20'h0_4321, 10'd20};
      tbl[7] = '{20'hD_105E, 10'd5};
      for (int i = 0; i < 8; i++) rom[i] = tbl[i].word;
      rst = 1; start = 0; act_in = ACT5; out_ready = 1; start1 = 0; act_in1 = ACT2;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_nrn_load", nrn_load, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_nrn_act", nrn_act, 0);
      chk("rst_nrn_rstn", nrn_rstn, 0);
      rst = 0;
      @(negedge clk);
      chk("nrn_rstn_released", nrn_rstn, 1);
      run_pass(-1, 0, -1, dc);
      chk("done_cycle_default", dc, 25);
      run_pass(2, 5, -1, dc);
      chk("done_cycle_backpressure", dc, 30);
      run_pass(-1, 0, 7, dc);
      chk("done_cycle_start_busy", dc, 25);
      chk("act_kept_after_busy_start", nrn_act, ACT2);
      // reset asserted during LOAD of idx 4 (cycle 14)
      start = 1; act_in = ACT2;
      @(negedge clk);
      start = 0;
      repeat (13) @(negedge clk);
      chk("load_idx4_state", nrn_load, 1);
      chk("load_idx4_addr", rom_addr, 4);
      rst = 1;
      #1 chk("rstn_during_rst", nrn_rstn, 0);
      @(negedge clk);
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_nrn_res", nrn_res, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_done", {done, out_valid}, 0);
      end
      run_pass(-1, 0, -1, dc);
      chk("done_cycle_after_abort", dc, 25);
      // single-neuron layer with start held high for back-to-back acceptance
      start1 = 1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 3) begin
            chk("n1_valid", out_valid1, 1);
            chk("n1_idx", out_idx1, 0);
            chk("n1_data", out_data1, 8);
         end
         if (c == 4) chk("n1_done", done1, 1);
         if (c == 5) chk("n1_idle", busy1, 0);
         if (c == 6) begin
            chk("n1_restart", busy1, 1);
            chk("n1_restart_fetch", rom_en1, 1);
            start1 = 0;
         end
      end
      repeat (8) @(negedge clk);
      chk("n1_drained", busy1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
